// File: rtl/operand_entry_fsm_pkg.sv
// Shared types and defaults for the operand entry front end.
// Phase codes double as the LED encoding.
package operand_entry_fsm_pkg;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } phase_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SYNTH_DEBOUNCE_CYCLES = 500000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/operand_entry_fsm_key_debouncer.sv
// Synchronises and debounces one active-low push button.
// Emits a one-cycle pulse after an accepted press.
module key_debouncer
  import operand_entry_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          prev_stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      stable      <= 1'b1;
      prev_stable <= 1'b1;
      cnt         <= '0;
    end else begin
      sync1       <= raw_n;
      sync2       <= sync1;
      prev_stable <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Only the falling edge of the accepted level is an event.
  assign press_pulse = prev_stable & ~stable;

endmodule

// File: rtl/operand_entry_fsm.sv
// Captures switch value as operand A then B on debounced enter presses.
// Clear press zeroes both operands and restarts the sequence.
module operand_entry_fsm
  import operand_entry_fsm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = SYNTH_DEBOUNCE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enter_n,
  input  logic             clear_n,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic [1:0]       phase
);

  logic enter_ev;
  logic clear_ev;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock       (clock),
    .reset       (reset),
    .raw_n       (enter_n),
    .press_pulse (enter_ev)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock       (clock),
    .reset       (reset),
    .raw_n       (clear_n),
    .press_pulse (clear_ev)
  );

  phase_e           state;
  phase_e           state_nx;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic             valid_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= WAIT_A;
      op_a           <= '0;
      op_b           <= '0;
      operands_valid <= 1'b0;
    end else begin
      state          <= state_nx;
      op_a           <= a_nx;
      op_b           <= b_nx;
      operands_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = op_a;
    b_nx     = op_b;
    valid_nx = 1'b0;
    if (clear_ev) begin
      state_nx = WAIT_A;
      a_nx     = '0;
      b_nx     = '0;
    end else begin
      case (state)
        WAIT_A: if (enter_ev) begin
          a_nx     = data_in;
          state_nx = WAIT_B;
        end
        WAIT_B: if (enter_ev) begin
          b_nx     = data_in;
          valid_nx = 1'b1;
          state_nx = READY;
        end
        READY: if (enter_ev) begin
          a_nx     = data_in;
          b_nx     = '0;
          state_nx = WAIT_B;
        end
        default: state_nx = WAIT_A;
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_operand_entry_fsm;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       enter_n;
  logic       clear_n;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       operands_valid;
  logic [1:0] phase;
  logic [8:0] sum;

  int checks = 0;
  int errors = 0;

  operand_entry_fsm #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .enter_n        (enter_n),
    .clear_n        (clear_n),
    .op_a           (op_a),
    .op_b           (op_b),
    .operands_valid (operands_valid),
    .phase          (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic quiet(input int n, input string tag);
    repeat (n) begin
      @(negedge clock);
      chk(tag, 32'(operands_valid), 32'd0);
    end
  endtask

  task automatic state_is(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [1:0] p);
    chk({tag, "_a"}, 32'(op_a), 32'(a));
    chk({tag, "_b"}, 32'(op_b), 32'(b));
    chk({tag, "_ph"}, 32'(phase), 32'(p));
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 8'h00;
    enter_n = 1'b1;
    clear_n = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    state_is("rst", 8'h00, 8'h00, 2'b00);
    chk("rst_v", 32'(operands_valid), 32'd0);

    // Operand A: enter low before edge 1, capture at edge 7
    data_in = 8'h3C;
    enter_n = 1'b0;
    cyc(6);
    chk("a_early", 32'(op_a), 32'h00);
    cyc(1);
    state_is("capA", 8'h3C, 8'h00, 2'b01);
    chk("capA_v", 32'(operands_valid), 32'd0);
    enter_n = 1'b1;
    quiet(8, "relA_v");

    // Operand B with valid pulse
    data_in = 8'hA5;
    enter_n = 1'b0;
    quiet(6, "preB_v");
    chk("b_early", 32'(op_b), 32'h00);
    cyc(1);
    state_is("capB", 8'h3C, 8'hA5, 2'b10);
    chk("capB_v", 32'(operands_valid), 32'd1);
    sum = {1'b0, op_a} + {1'b0, op_b};
    chk("sum", 32'(sum), 32'h0E1);
    data_in = 8'h00;
    cyc(1);
    chk("v_once", 32'(operands_valid), 32'd0);
    chk("hold_b", 32'(op_b), 32'hA5);
    enter_n = 1'b1;
    quiet(8, "relB_v");

    // Short glitch: no event
    data_in = 8'h99;
    enter_n = 1'b0;
    cyc(3);
    enter_n = 1'b1;
    quiet(12, "glitch_v");
    state_is("glitch", 8'h3C, 8'hA5, 2'b10);

    // READY + enter starts a new pair; long hold gives one event
    data_in = 8'hFF;
    enter_n = 1'b0;
    quiet(7, "newpair_v");
    state_is("newpair", 8'hFF, 8'h00, 2'b01);
    data_in = 8'h12;
    quiet(12, "hold_v");
    state_is("hold", 8'hFF, 8'h00, 2'b01);
    enter_n = 1'b1;
    quiet(8, "relC_v");

    // Clear and enter together: clear wins
    data_in = 8'h5A;
    enter_n = 1'b0;
    clear_n = 1'b0;
    quiet(6, "both_pre_v");
    chk("both_early", 32'(op_a), 32'hFF);
    cyc(1);
    state_is("both", 8'h00, 8'h00, 2'b00);
    chk("both_v", 32'(operands_valid), 32'd0);
    enter_n = 1'b1;
    clear_n = 1'b1;
    quiet(8, "relD_v");

    // Get into WAIT_B with a nonzero operand
    data_in = 8'h77;
    enter_n = 1'b0;
    cyc(7);
    state_is("capA2", 8'h77, 8'h00, 2'b01);
    enter_n = 1'b1;
    cyc(8);

    // Reset mid-debounce (counter at 2), button held through reset
    data_in = 8'h11;
    enter_n = 1'b0;
    cyc(4);
    reset = 1'b1;
    #1;
    state_is("async_rst", 8'h00, 8'h00, 2'b00);
    cyc(2);
    reset = 1'b0;
    quiet(6, "post_rst_v");
    chk("post_rst_a", 32'(op_a), 32'h00);
    cyc(1);
    state_is("held_rst", 8'h11, 8'h00, 2'b01);
    quiet(10, "held_rst_v");
    chk("held_rst_ph", 32'(phase), 32'b01);
    enter_n = 1'b1;

    // Reset at counter 2 with button released during reset: no event
    cyc(8);
    data_in = 8'h22;
    enter_n = 1'b0;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    enter_n = 1'b1;
    cyc(1);
    reset = 1'b0;
    quiet(12, "no_ev_v");
    state_is("no_ev", 8'h00, 8'h00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
